lector_ram: RTL and testbench
=============================

Name: lector_ram

Overview:
- Read-only responder for the on-board cellular RAM (async mode) holding the drum/music sample tables.
- Consumes the 26-bit byte addresses produced by the address walker and performs one word read per request.
- Returns the 16-bit word plus the addressed 8-bit sample, with a one-cycle valid strobe.
- Sits between the address walker and the external RAM pins; also owns the RAM control lines.

Parameters:
- CICLOS_ESPERA, 4, clock cycles with CS/OE asserted before data capture (4 × 20 ns ≥ 70 ns tAA at 50 MHz); legal range 1..15.
- LIMITE_SUP, 26'h0FFFFFF, highest byte address the RAM can serve; anything above is out of range.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- solicitud  input  1  read request, sampled only in REPOSO
- DireccionRAM  input  26  byte address of the request
- ocupado  output  1  high from acceptance until return to REPOSO
- DatoValido  output  1  one-cycle strobe: Dato/Muestra/FueraRango valid
- Dato  output  16  captured RAM word
- Muestra  output  8  byte selected by latched address bit 0 (0 = low byte, 1 = high byte)
- FueraRango  output  1  latched with DatoValido; the request exceeded LIMITE_SUP
- MemAdr  output  23  word address to RAM (byte address bits 23:1)
- MemDB  input  16  RAM data bus (read-only use)
- RamCS_n  output  1  chip select, active low
- MemOE_n  output  1  output enable, active low
- MemWE_n  output  1  write enable, tied high (never writes)
- RamAdv_n  output  1  held low (async mode)
- RamClk  output  1  held low
- RamLB_n  output  1  held low during access, else high
- RamUB_n  output  1  held low during access, else high

Behaviour:
- Reset, asynchronous:
  - state REPOSO, counter 0.
  - ocupado=0, DatoValido=0, Dato=0, Muestra=0, FueraRango=0, MemAdr=0.
  - RamCS_n=1, MemOE_n=1, RamLB_n=1, RamUB_n=1.
  - Effective immediately, including mid-access; the access is abandoned and no DatoValido is produced.
- States:
  - REPOSO:
    - solicitud=1 at an edge → latch DireccionRAM.
    - If address ≤ LIMITE_SUP → ACCESO; else → FALLO.
    - solicitud=0 → stay.
  - ACCESO:
    - MemAdr = latched[23:1]; RamCS_n, MemOE_n, RamLB_n, RamUB_n = 0.
    - Counter runs 0..CICLOS_ESPERA-1.
    - On the edge ending the last count: Dato <= MemDB; Muestra <= latched[0] ? MemDB[15:8] : MemDB[7:0]; → ENTREGA.
  - ENTREGA:
    - RamCS_n and MemOE_n high (recovery cycle); DatoValido=1; FueraRango=0.
    - Next state REPOSO.
  - FALLO:
    - No RAM access; RamCS_n stays high.
    - DatoValido=1, FueraRango=1; Dato and Muestra keep their previous values.
    - Next state REPOSO.
- ocupado: high in ACCESO, ENTREGA and FALLO; low in REPOSO.
- Latency, request sampled at edge 0:
  - In range: DatoValido high during cycle CICLOS_ESPERA+1 (5 cycles at default); next request accepted at edge CICLOS_ESPERA+2.
  - Out of range: DatoValido in cycle 1; REPOSO from edge 2.
- solicitud while ocupado=1 is ignored, not queued. Requester holds or re-issues after ocupado falls.
- solicitud held high continuously gives back-to-back reads every CICLOS_ESPERA+2 cycles, each with a freshly sampled address.
- DireccionRAM changes during an access have no effect; the address is latched.
- Address bits 25:24 are only used for the range check.
- Dato, Muestra and FueraRango hold their values until the next ENTREGA/FALLO.
- MemWE_n=1, RamAdv_n=0, RamClk=0 at all times, including during reset.

Decomposition:
- Shared package:
  - state encoding (REPOSO, ACCESO, ENTREGA, FALLO, 2 bits);
  - LIMITE_SUP default;
  - RAM control idle/active levels.
- No sub-module; a single FSM with wait counter and capture registers.

Test Plan:
- Reset then idle: all outputs at reset values; MemWE_n=1, RamCS_n=1 throughout.
- solicitud pulse with DireccionRAM=26'h000004, memory model returns 16'hA55A → MemAdr=23'h000002.
  - CS/OE low exactly 4 cycles.
  - DatoValido at cycle 5 with Dato=16'hA55A, Muestra=8'h5A, FueraRango=0.
- Address 26'h000007 with word 16'h1234 → MemAdr=23'h000003, Muestra=8'h12.
- Address 26'h2000000 → no CS assertion; DatoValido at cycle 1 with FueraRango=1; Dato unchanged.
- solicitud held high with addresses 0, 2, 4 → three DatoValido strobes 6 cycles apart.
  - Pulses issued while ocupado=1 produce no extra strobe.
- reset asserted during cycle 2 of ACCESO → RamCS_n/MemOE_n go high asynchronously; no DatoValido.
  - After release, a fresh request completes normally.

Source files
------------

// File: rtl/lector_ram_pkg.sv
// Shared definitions for the cellular-RAM sample reader: FSM encoding,
// address limit and RAM control line levels.
`timescale 1ns/1ps
package lector_ram_pkg;

  typedef enum logic [1:0] {
    Reposo  = 2'd0,
    Acceso  = 2'd1,
    Entrega = 2'd2,
    Fallo   = 2'd3
  } estado_t;

  localparam logic [25:0] LIMITE_SUP_DEF = 26'h0FFFFFF;

  // RAM control strobes are all active low.
  localparam logic CTRL_ACTIVO   = 1'b0;
  localparam logic CTRL_INACTIVO = 1'b1;

  function automatic logic en_rango(input logic [25:0] dir, input logic [25:0] limite);
    return dir <= limite;
  endfunction

endpackage

// File: rtl/lector_ram.sv
// Read-only responder for the async cellular RAM: one word read per request,
// returning the word, the addressed byte and an out-of-range flag.
`timescale 1ns/1ps
module lector_ram
  import lector_ram_pkg::*;
#(
  parameter int unsigned CICLOS_ESPERA = 4,
  parameter logic [25:0] LIMITE_SUP    = LIMITE_SUP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        solicitud,
  input  logic [25:0] DireccionRAM,
  output logic        ocupado,
  output logic        DatoValido,
  output logic [15:0] Dato,
  output logic [7:0]  Muestra,
  output logic        FueraRango,
  output logic [22:0] MemAdr,
  input  logic [15:0] MemDB,
  output logic        RamCS_n,
  output logic        MemOE_n,
  output logic        MemWE_n,
  output logic        RamAdv_n,
  output logic        RamClk,
  output logic        RamLB_n,
  output logic        RamUB_n
);

  localparam logic [3:0] ULTIMA = 4'(CICLOS_ESPERA - 1);

  estado_t    estado_q;
  logic [3:0] cuenta_q;
  logic       sel_alto_q;

  // Async mode, read only: these lines never move.
  assign MemWE_n  = CTRL_INACTIVO;
  assign RamAdv_n = CTRL_ACTIVO;
  assign RamClk   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= Reposo;
      cuenta_q   <= '0;
      sel_alto_q <= 1'b0;
      ocupado    <= 1'b0;
      DatoValido <= 1'b0;
      Dato       <= '0;
      Muestra    <= '0;
      FueraRango <= 1'b0;
      MemAdr     <= '0;
      RamCS_n    <= CTRL_INACTIVO;
      MemOE_n    <= CTRL_INACTIVO;
      RamLB_n    <= CTRL_INACTIVO;
      RamUB_n    <= CTRL_INACTIVO;
    end else begin
      DatoValido <= 1'b0;
      unique case (estado_q)
        Reposo: begin
          if (solicitud) begin
            ocupado    <= 1'b1;
            cuenta_q   <= '0;
            sel_alto_q <= DireccionRAM[0];
            if (en_rango(DireccionRAM, LIMITE_SUP)) begin
              estado_q <= Acceso;
              MemAdr   <= DireccionRAM[23:1];
              RamCS_n  <= CTRL_ACTIVO;
              MemOE_n  <= CTRL_ACTIVO;
              RamLB_n  <= CTRL_ACTIVO;
              RamUB_n  <= CTRL_ACTIVO;
            end else begin
              // Out of range: report straight away, RAM stays deselected.
              estado_q   <= Fallo;
              DatoValido <= 1'b1;
              FueraRango <= 1'b1;
            end
          end
        end
        Acceso: begin
          if (cuenta_q == ULTIMA) begin
            Dato       <= MemDB;
            Muestra    <= sel_alto_q ? MemDB[15:8] : MemDB[7:0];
            FueraRango <= 1'b0;
            DatoValido <= 1'b1;
            RamCS_n    <= CTRL_INACTIVO;
            MemOE_n    <= CTRL_INACTIVO;
            RamLB_n    <= CTRL_INACTIVO;
            RamUB_n    <= CTRL_INACTIVO;
            estado_q   <= Entrega;
          end else begin
            cuenta_q <= cuenta_q + 4'd1;
          end
        end
        Entrega, Fallo: begin
          ocupado  <= 1'b0;
          estado_q <= Reposo;
        end
        default: begin
          ocupado  <= 1'b0;
          estado_q <= Reposo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lector_ram.sv
// Self-checking bench for lector_ram: scoreboard of expected strobes plus
// per-scenario latency, RAM control and reset checks.
`timescale 1ns/1ps
module tb_lector_ram;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  m;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        solicitud;
  logic [25:0] DireccionRAM;
  logic        ocupado, DatoValido, FueraRango;
  logic [15:0] Dato, MemDB;
  logic [7:0]  Muestra;
  logic [22:0] MemAdr;
  logic        RamCS_n, MemOE_n, MemWE_n, RamAdv_n, RamClk, RamLB_n, RamUB_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobes = 0;
  int cs_cycles = 0;
  int oe_cycles = 0;
  bit const_bad = 1'b0;
  int strobe_cyc[$];
  exp_t sb[$];
  logic [15:0] mem [16];
  logic [15:0] prev_dato;
  logic [7:0]  prev_muestra;

  lector_ram dut (
    .clk(clk), .reset(reset), .solicitud(solicitud), .DireccionRAM(DireccionRAM),
    .ocupado(ocupado), .DatoValido(DatoValido), .Dato(Dato), .Muestra(Muestra),
    .FueraRango(FueraRango), .MemAdr(MemAdr), .MemDB(MemDB), .RamCS_n(RamCS_n),
    .MemOE_n(MemOE_n), .MemWE_n(MemWE_n), .RamAdv_n(RamAdv_n), .RamClk(RamClk),
    .RamLB_n(RamLB_n), .RamUB_n(RamUB_n)
  );

  always #5 clk = ~clk;

  assign MemDB = mem[MemAdr[3:0]];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (MemWE_n !== 1'b1 || RamAdv_n !== 1'b0 || RamClk !== 1'b0) const_bad = 1'b1;
    if (RamCS_n === 1'b0) cs_cycles++;
    if (MemOE_n === 1'b0) oe_cycles++;
    if (!reset && DatoValido === 1'b1) begin
      n_strobes++;
      strobe_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe dato=%h muestra=%h fuera=%b", Dato, Muestra, FueraRango);
      end else begin
        e = sb.pop_front();
        if ({Dato, Muestra, FueraRango} !== e) begin
          errors++;
          $display("FAIL strobe_data dato=%h exp %h muestra=%h exp %h fuera=%b exp %b",
                   Dato, e.d, Muestra, e.m, FueraRango, e.f);
        end
      end
    end
  end

  task automatic do_read(input logic [25:0] addr, input logic [15:0] exp_d,
                         input logic [7:0] exp_m, input logic exp_f, input int exp_lat,
                         input int exp_cs, input logic [22:0] exp_adr);
    int c0;
    int lat;
    bit seen;
    @(posedge clk); #1;
    solicitud = 1'b1;
    DireccionRAM = addr;
    sb.push_back('{d: exp_d, m: exp_m, f: exp_f});
    cs_cycles = 0;
    oe_cycles = 0;
    @(posedge clk); #1;
    c0 = cyc;
    solicitud = 1'b0;
    DireccionRAM = 26'h3FFFFFF;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (DatoValido === 1'b1) begin
        seen = 1'b1;
        lat = cyc - c0 + 1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL strobe_timeout addr=%h no DatoValido within 20 cycles", addr);
    end else if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h got %0d exp %0d", addr, lat, exp_lat);
    end
    checks++;
    if (cs_cycles != exp_cs || oe_cycles != exp_cs) begin
      errors++;
      $display("FAIL cs_oe_cycles addr=%h cs=%0d oe=%0d exp %0d", addr, cs_cycles, oe_cycles,
               exp_cs);
    end
    if (!exp_f) begin
      checks++;
      if (MemAdr !== exp_adr) begin
        errors++;
        $display("FAIL memadr addr=%h got %h exp %h", addr, MemAdr, exp_adr);
      end
      prev_dato = exp_d;
      prev_muestra = exp_m;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    solicitud = 1'b0;
    DireccionRAM = '0;
    #1;
    checks++;
    if ({ocupado, DatoValido, FueraRango} !== 3'b000 || Dato !== 16'h0 || Muestra !== 8'h0
        || MemAdr !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs oc=%b dv=%b fr=%b dato=%h mu=%h adr=%h exp all zero",
               ocupado, DatoValido, FueraRango, Dato, Muestra, MemAdr);
    end
    checks++;
    if ({RamCS_n, MemOE_n, RamLB_n, RamUB_n} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1111", {RamCS_n, MemOE_n, RamLB_n, RamUB_n});
    end
    checks++;
    if ({MemWE_n, RamAdv_n, RamClk} !== 3'b100) begin
      errors++;
      $display("FAIL reset_const got %b exp 100", {MemWE_n, RamAdv_n, RamClk});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cs_cycles = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_strobes != 0 || cs_cycles != 0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL idle strobes=%0d cs_cycles=%0d oc=%b exp 0 0 0", n_strobes, cs_cycles,
               ocupado);
    end
    prev_dato = 16'h0;
    prev_muestra = 8'h0;
  endtask

  task automatic test_low_byte();
    do_read(26'h0000004, 16'hA55A, 8'h5A, 1'b0, 5, 4, 23'h000002);
  endtask

  task automatic test_high_byte();
    do_read(26'h0000007, 16'h1234, 8'h12, 1'b0, 5, 4, 23'h000003);
  endtask

  task automatic test_out_of_range();
    do_read(26'h2000000, prev_dato, prev_muestra, 1'b1, 1, 0, 23'h0);
    @(posedge clk); #1;
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL fallo_return ocupado=%b exp 0", ocupado);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int idx;
    base = n_strobes;
    idx = strobe_cyc.size();
    @(posedge clk); #1;
    solicitud = 1'b1;
    DireccionRAM = 26'h0;
    sb.push_back('{d: 16'hBEEF, m: 8'hEF, f: 1'b0});
    sb.push_back('{d: 16'hCAFE, m: 8'hFE, f: 1'b0});
    sb.push_back('{d: 16'hA55A, m: 8'h5A, f: 1'b0});
    @(posedge clk); #1;
    DireccionRAM = 26'h2;
    repeat (6) @(posedge clk);
    #1;
    DireccionRAM = 26'h4;
    repeat (6) @(posedge clk);
    #1;
    solicitud = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_strobes - base != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", n_strobes - base);
    end else begin
      checks++;
      if (strobe_cyc[idx+1] - strobe_cyc[idx] != 6 || strobe_cyc[idx+2] - strobe_cyc[idx+1] != 6)
      begin
        errors++;
        $display("FAIL b2b_spacing got %0d,%0d exp 6,6", strobe_cyc[idx+1] - strobe_cyc[idx],
                 strobe_cyc[idx+2] - strobe_cyc[idx+1]);
      end
    end
    prev_dato = 16'hA55A;
    prev_muestra = 8'h5A;
  endtask

  task automatic test_busy_ignored();
    int base;
    base = n_strobes;
    @(posedge clk); #1;
    solicitud = 1'b1;
    DireccionRAM = 26'h10;
    sb.push_back('{d: 16'h0F0E, m: 8'h0E, f: 1'b0});
    @(posedge clk); #1;
    solicitud = 1'b0;
    @(posedge clk); #1;
    solicitud = 1'b1;
    DireccionRAM = 26'h7;
    @(posedge clk); #1;
    solicitud = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    solicitud = 1'b1;
    @(posedge clk); #1;
    solicitud = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_strobes - base != 1) begin
      errors++;
      $display("FAIL busy_ignored strobes=%0d exp 1", n_strobes - base);
    end
    prev_dato = 16'h0F0E;
    prev_muestra = 8'h0E;
  endtask

  task automatic test_reset_mid_access();
    int base;
    base = n_strobes;
    @(posedge clk); #1;
    solicitud = 1'b1;
    DireccionRAM = 26'h4;
    @(posedge clk); #1;
    solicitud = 1'b0;
    @(posedge clk); #3;
    checks++;
    if (RamCS_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_access_cs RamCS_n=%b exp 0", RamCS_n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({RamCS_n, MemOE_n, ocupado, DatoValido} !== 4'b1100 || Dato !== 16'h0) begin
      errors++;
      $display("FAIL async_reset cs/oe/oc/dv=%b dato=%h exp 1100 0000",
               {RamCS_n, MemOE_n, ocupado, DatoValido}, Dato);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev_dato = 16'h0;
    prev_muestra = 8'h0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_strobes != base) begin
      errors++;
      $display("FAIL abandoned_access strobes=%0d exp %0d", n_strobes, base);
    end
    do_read(26'h0000004, 16'hA55A, 8'h5A, 1'b0, 5, 4, 23'h000002);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0] = 16'hBEEF;
    mem[1] = 16'hCAFE;
    mem[2] = 16'hA55A;
    mem[3] = 16'h1234;
    mem[8] = 16'h0F0E;
    test_reset();
    test_low_byte();
    test_high_byte();
    test_out_of_range();
    test_back_to_back();
    test_busy_ignored();
    test_out_of_range();
    test_reset_mid_access();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left pending=%0d exp 0", sb.size());
    end
    checks++;
    if (const_bad) begin
      errors++;
      $display("FAIL const_lines got toggling exp MemWE_n=1 RamAdv_n=0 RamClk=0");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
